// File: rtl/fp_div_iterative_pkg.sv
// Shared FPU definitions: field widths, constants, FSM state type and IEEE-754 classify helpers.
package fpu_pkg;

  localparam int          EXP_BIAS  = 127;
  localparam logic [7:0]  EXP_MAX   = 8'hFF;
  localparam logic [31:0] QNAN      = 32'h7FC0_0000;
  localparam int          MANT_W    = 24;
  localparam int          DIV_ITERS = 25;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DIV  = 2'd1,
    NORM = 2'd2,
    DONE = 2'd3
  } fsm_state_e;

  typedef struct packed {
    logic overflow;
    logic underflow;
    logic div_by_zero;
    logic invalid;
  } fp_flags_t;

  function automatic logic [7:0] exp_of(input logic [31:0] x);
    return x[30:23];
  endfunction

  function automatic logic [22:0] frac_of(input logic [31:0] x);
    return x[22:0];
  endfunction

  // Exponent 0 means zero regardless of fraction: no subnormal support.
  function automatic logic is_zero(input logic [31:0] x);
    return (x[30:23] == 8'h00);
  endfunction

  function automatic logic is_inf(input logic [31:0] x);
    return (x[30:23] == EXP_MAX) && (x[22:0] == 23'd0);
  endfunction

  function automatic logic is_nan(input logic [31:0] x);
    return (x[30:23] == EXP_MAX) && (x[22:0] != 23'd0);
  endfunction

endpackage

// File: rtl/fp_div_iterative_if.sv
// Operand/result handshake bundle for the iterative divider.
interface fp_div_iterative_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] A;
  logic [31:0] B;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        overflow;
  logic        underflow;
  logic        div_by_zero;
  logic        invalid;

  modport master (
    output in_valid, A, B, out_ready,
    input  in_ready, out_valid, result, overflow, underflow, div_by_zero, invalid
  );

  modport slave (
    input  in_valid, A, B, out_ready,
    output in_ready, out_valid, result, overflow, underflow, div_by_zero, invalid
  );
endinterface

// File: rtl/fp_div_iterative_mant_div_core.sv
// Restoring mantissa divider: one quotient bit per cycle, DIV_ITERS cycles after start.
module mant_div_core
  import fpu_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [MANT_W-1:0] m_a,
  input  logic [MANT_W-1:0] m_b,
  output logic              busy,
  output logic              done,
  output logic [MANT_W:0]   q
);

  logic [MANT_W:0]   rem_q, rem_d;
  logic [MANT_W:0]   q_q, q_d;
  logic [MANT_W:0]   diff_s;
  logic [MANT_W-1:0] mb_q, mb_d;
  logic [4:0]        cnt_q, cnt_d;
  logic              busy_q, busy_d;
  logic              ge_s;

  // Compare/subtract step and register next-state selection.
  always_comb begin
    ge_s   = (rem_q >= {1'b0, mb_q});
    diff_s = ge_s ? (rem_q - {1'b0, mb_q}) : rem_q;
    rem_d  = rem_q;
    q_d    = q_q;
    mb_d   = mb_q;
    cnt_d  = cnt_q;
    busy_d = busy_q;
    if (start) begin
      rem_d  = {1'b0, m_a};
      q_d    = {(MANT_W+1){1'b0}};
      mb_d   = m_b;
      cnt_d  = 5'd0;
      busy_d = 1'b1;
    end else if (busy_q) begin
      // Remainder stays below 2*mB after the shift, so 25 bits never overflow.
      rem_d  = diff_s << 1;
      q_d    = {q_q[MANT_W-1:0], ge_s};
      cnt_d  = cnt_q + 5'd1;
      busy_d = (cnt_q != 5'(DIV_ITERS - 1));
    end else begin
      busy_d = 1'b0;
    end
  end

  // Divider state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem_q  <= {(MANT_W+1){1'b0}};
      q_q    <= {(MANT_W+1){1'b0}};
      mb_q   <= {MANT_W{1'b0}};
      cnt_q  <= 5'd0;
      busy_q <= 1'b0;
    end else begin
      rem_q  <= rem_d;
      q_q    <= q_d;
      mb_q   <= mb_d;
      cnt_q  <= cnt_d;
      busy_q <= busy_d;
    end
  end

  assign busy = busy_q;
  assign done = busy_q && (cnt_q == 5'(DIV_ITERS - 1));
  assign q    = q_q;

endmodule

// File: rtl/fp_div_iterative.sv
// Iterative IEEE-754 single divider: handshake FSM, special cases, exponent path and normalization.
module fp_div_iterative
  import fpu_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  fp_div_iterative_if.slave   bus
);

  fsm_state_e         state_q, state_d;
  logic               sign_q, sign_d;
  logic signed [9:0]  exp_q, exp_d;
  logic [31:0]        result_q, result_d;
  fp_flags_t          flags_q, flags_d;
  logic               out_valid_q, out_valid_d;

  logic               start_s;
  logic               core_busy_s, core_done_s;
  logic [MANT_W:0]    q_s;
  logic               spec_hit_s;
  logic [31:0]        spec_result_s;
  fp_flags_t          spec_flags_s;
  logic               spec_sign_s;
  logic signed [9:0]  adj_exp_s;
  logic [22:0]        mant_s;

  mant_div_core u_core (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start_s),
    .m_a   ({1'b1, frac_of(bus.A)}),
    .m_b   ({1'b1, frac_of(bus.B)}),
    .busy  (core_busy_s),
    .done  (core_done_s),
    .q     (q_s)
  );

  // Special-operand classification; first matching rule wins.
  always_comb begin
    spec_sign_s   = bus.A[31] ^ bus.B[31];
    spec_hit_s    = 1'b1;
    spec_result_s = 32'h0000_0000;
    spec_flags_s  = fp_flags_t'(4'b0000);
    if (is_nan(bus.A) || is_nan(bus.B) ||
        (is_zero(bus.A) && is_zero(bus.B)) ||
        (is_inf(bus.A) && is_inf(bus.B))) begin
      spec_result_s        = QNAN;
      spec_flags_s.invalid = 1'b1;
    end else if (is_inf(bus.A)) begin
      spec_result_s = {spec_sign_s, EXP_MAX, 23'd0};
    end else if (is_zero(bus.B)) begin
      spec_result_s            = {spec_sign_s, EXP_MAX, 23'd0};
      spec_flags_s.div_by_zero = 1'b1;
    end else if (is_zero(bus.A) || is_inf(bus.B)) begin
      spec_result_s = {spec_sign_s, 8'h00, 23'd0};
    end else begin
      spec_hit_s = 1'b0;
    end
  end

  // Quotient in (0.5, 2): an integer bit of 0 costs one exponent step.
  always_comb begin
    if (q_s[MANT_W]) begin
      adj_exp_s = exp_q;
      mant_s    = q_s[23:1];
    end else begin
      adj_exp_s = exp_q - 10'sd1;
      mant_s    = q_s[22:0];
    end
  end

  // Control FSM next-state and output register selection.
  always_comb begin
    state_d     = state_q;
    sign_d      = sign_q;
    exp_d       = exp_q;
    result_d    = result_q;
    flags_d     = flags_q;
    out_valid_d = out_valid_q;
    start_s     = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          sign_d  = spec_sign_s;
          exp_d   = $signed({2'b00, exp_of(bus.A)}) - $signed({2'b00, exp_of(bus.B)})
                    + $signed(10'(EXP_BIAS));
          flags_d = fp_flags_t'(4'b0000);
          if (spec_hit_s) begin
            result_d = spec_result_s;
            flags_d  = spec_flags_s;
            state_d  = DONE;
          end else begin
            start_s = 1'b1;
            state_d = DIV;
          end
        end else begin
          state_d = IDLE;
        end
      end
      DIV: begin
        if (core_done_s) begin
          state_d = NORM;
        end else if (core_busy_s) begin
          state_d = DIV;
        end else begin
          state_d = IDLE;
        end
      end
      NORM: begin
        out_valid_d = 1'b1;
        state_d     = DONE;
        if (adj_exp_s >= 10'sd255) begin
          result_d         = {sign_q, EXP_MAX, 23'd0};
          flags_d.overflow = 1'b1;
        end else if (adj_exp_s <= 10'sd0) begin
          result_d          = {sign_q, 8'h00, 23'd0};
          flags_d.underflow = 1'b1;
        end else begin
          result_d = {sign_q, adj_exp_s[7:0], mant_s};
        end
      end
      DONE: begin
        // Special results enter DONE with valid low and present one edge later.
        if (!out_valid_q) begin
          out_valid_d = 1'b1;
        end else if (bus.out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end else begin
          out_valid_d = 1'b1;
        end
      end
      default: begin
        out_valid_d = 1'b0;
        state_d     = IDLE;
      end
    endcase
  end

  // FSM and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      sign_q      <= 1'b0;
      exp_q       <= 10'sd0;
      result_q    <= 32'h0000_0000;
      flags_q     <= fp_flags_t'(4'b0000);
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      sign_q      <= sign_d;
      exp_q       <= exp_d;
      result_q    <= result_d;
      flags_q     <= flags_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign bus.in_ready    = (state_q == IDLE);
  assign bus.out_valid   = out_valid_q;
  assign bus.result      = result_q;
  assign bus.overflow    = flags_q.overflow;
  assign bus.underflow   = flags_q.underflow;
  assign bus.div_by_zero = flags_q.div_by_zero;
  assign bus.invalid     = flags_q.invalid;

endmodule

// File: tb/tb_fp_div_iterative.sv
// Directed self-checking bench for fp_div_iterative: values, flags, latency, hold and reset abort.
module tb_fp_div_iterative;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  fp_div_iterative_if bus();

  fp_div_iterative dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic [3:0]  flg;  // {overflow, underflow, div_by_zero, invalid}
    int          lat;
  } vec_t;

  function automatic logic [3:0] flags_now();
    return {bus.overflow, bus.underflow, bus.div_by_zero, bus.invalid};
  endfunction

  task automatic drive_op(input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.A        = a;
    bus.B        = b;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_valid(output int cyc);
    cyc = -1;
    for (int i = 1; i <= 60; i++) begin
      @(posedge clk);
      #1;
      if (bus.out_valid) begin
        cyc = i;
        break;
      end
    end
  endtask

  task automatic ack();
    @(negedge clk);
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    #2;
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", bus.out_valid); end
    checks++; if (bus.result !== 32'h0) begin errors++; $display("FAIL reset_result got %h want 00000000", bus.result); end
    checks++; if (flags_now() !== 4'b0000) begin errors++; $display("FAIL reset_flags got %b want 0000", flags_now()); end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", bus.in_ready); end
  endtask

  task automatic test_normal();
    vec_t v[9];
    int   cyc;
    v[0] = '{32'h40C00000, 32'h40000000, 32'h40400000, 4'b0000, 26}; // 6/2
    v[1] = '{32'h3F800000, 32'h40400000, 32'h3EAAAAAA, 4'b0000, 26}; // 1/3 truncated
    v[2] = '{32'hBFC00000, 32'h3F000000, 32'hC0400000, 4'b0000, 26}; // -1.5/0.5
    v[3] = '{32'h7F000000, 32'h3E800000, 32'h7F800000, 4'b1000, 26}; // overflow
    v[4] = '{32'h00800000, 32'h40000000, 32'h00000000, 4'b0100, 26}; // underflow
    v[5] = '{32'h7F000000, 32'h3F800000, 32'h7F000000, 4'b0000, 26}; // exp 254 edge
    v[6] = '{32'h00800000, 32'h3F800000, 32'h00800000, 4'b0000, 26}; // exp 1 edge
    v[7] = '{32'h00800000, 32'h3FC00000, 32'h00000000, 4'b0100, 26}; // exp 1 - 1 = 0
    v[8] = '{32'h3F800000, 32'h3F800000, 32'h3F800000, 4'b0000, 26}; // 1/1
    for (int i = 0; i < 9; i++) begin
      drive_op(v[i].a, v[i].b);
      wait_valid(cyc);
      checks++; if (cyc != v[i].lat) begin errors++; $display("FAIL normal_latency[%0d] got %0d want %0d", i, cyc, v[i].lat); end
      checks++; if (bus.result !== v[i].res) begin errors++; $display("FAIL normal_result[%0d] got %h want %h", i, bus.result, v[i].res); end
      checks++; if (flags_now() !== v[i].flg) begin errors++; $display("FAIL normal_flags[%0d] got %b want %b", i, flags_now(), v[i].flg); end
      ack();
      checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL normal_in_ready[%0d] got %b want 1", i, bus.in_ready); end
    end
  endtask

  task automatic test_special();
    vec_t v[8];
    int   cyc;
    v[0] = '{32'h3F800000, 32'h00000000, 32'h7F800000, 4'b0010, 1}; // 1/0
    v[1] = '{32'h00000000, 32'h00000000, 32'h7FC00000, 4'b0001, 1}; // 0/0
    v[2] = '{32'h7F800001, 32'h3F800000, 32'h7FC00000, 4'b0001, 1}; // NaN/1
    v[3] = '{32'h7F800000, 32'hFF800000, 32'h7FC00000, 4'b0001, 1}; // inf/-inf
    v[4] = '{32'hFF800000, 32'h40000000, 32'hFF800000, 4'b0000, 1}; // -inf/2
    v[5] = '{32'h00000000, 32'hC0A00000, 32'h80000000, 4'b0000, 1}; // 0/-5
    v[6] = '{32'h40000000, 32'h7F800000, 32'h00000000, 4'b0000, 1}; // 2/inf
    v[7] = '{32'hBF800000, 32'h80000000, 32'h7F800000, 4'b0010, 1}; // -1/-0
    for (int i = 0; i < 8; i++) begin
      drive_op(v[i].a, v[i].b);
      wait_valid(cyc);
      checks++; if (cyc != v[i].lat) begin errors++; $display("FAIL special_latency[%0d] got %0d want %0d", i, cyc, v[i].lat); end
      checks++; if (bus.result !== v[i].res) begin errors++; $display("FAIL special_result[%0d] got %h want %h", i, bus.result, v[i].res); end
      checks++; if (flags_now() !== v[i].flg) begin errors++; $display("FAIL special_flags[%0d] got %b want %b", i, flags_now(), v[i].flg); end
      ack();
    end
  endtask

  task automatic test_hold();
    int cyc;
    drive_op(32'h40C00000, 32'h40000000);
    wait_valid(cyc);
    checks++; if (cyc != 26) begin errors++; $display("FAIL hold_latency got %0d want 26", cyc); end
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.A        = 32'h3F800000;
    bus.B        = 32'h00000000;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL hold_valid[%0d] got %b want 1", i, bus.out_valid); end
      checks++; if (bus.result !== 32'h40400000) begin errors++; $display("FAIL hold_result[%0d] got %h want 40400000", i, bus.result); end
      checks++; if (flags_now() !== 4'b0000) begin errors++; $display("FAIL hold_flags[%0d] got %b want 0000", i, flags_now()); end
      checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL hold_in_ready[%0d] got %b want 0", i, bus.in_ready); end
    end
    @(negedge clk);
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL hold_release_valid got %b want 0", bus.out_valid); end
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL hold_release_in_ready got %b want 1", bus.in_ready); end
    repeat (5) @(posedge clk);
    #1;
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL hold_no_queue_valid got %b want 0", bus.out_valid); end
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL hold_no_queue_in_ready got %b want 1", bus.in_ready); end
  endtask

  task automatic test_reset_mid_div();
    int cyc;
    int seen;
    drive_op(32'h40C00000, 32'h40000000);
    repeat (12) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL abort_valid got %b want 0", bus.out_valid); end
    checks++; if (bus.result !== 32'h0) begin errors++; $display("FAIL abort_result got %h want 00000000", bus.result); end
    checks++; if (flags_now() !== 4'b0000) begin errors++; $display("FAIL abort_flags got %b want 0000", flags_now()); end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL abort_in_ready got %b want 1", bus.in_ready); end
    seen = 0;
    repeat (30) begin
      @(posedge clk);
      #1;
      if (bus.out_valid) seen++;
    end
    checks++; if (seen != 0) begin errors++; $display("FAIL abort_no_result got %0d valid cycles want 0", seen); end
    drive_op(32'hC1200000, 32'h40A00000);
    wait_valid(cyc);
    checks++; if (cyc != 26) begin errors++; $display("FAIL post_abort_latency got %0d want 26", cyc); end
    checks++; if (bus.result !== 32'hC0000000) begin errors++; $display("FAIL post_abort_result got %h want c0000000", bus.result); end
    checks++; if (flags_now() !== 4'b0000) begin errors++; $display("FAIL post_abort_flags got %b want 0000", flags_now()); end
    ack();
  endtask

  initial begin
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.A         = 32'h0;
    bus.B         = 32'h0;
    test_reset();
    test_normal();
    test_special();
    test_hold();
    test_reset_mid_div();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
